pipe_ctrl: RTL and testbench

Central pipeline sequencing controller for the core. Arbitrates jump, interrupt and stall requests from EX, the bus interface and CLINT. Drives the PC update and per-stage keep/bubble controls; `flush_o` connects directly to the `hold_en` input of each stage's `gen_pipe_dff`, so asserting a bit loads that stage's default (NOP) value. Also watches for a hung bus with a timeout counter.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencing
// controller.
//   pc_state_e        : controller state (run / redirect bubble)
//   STG_IFID/IDEX/EXWB: bit positions of each stage in stall_o / flush_o
//   NSTG              : number of pipeline stage registers controlled
package pipe_ctrl_pkg;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_FLUSH = 1'b1
  } pc_state_e;

  localparam int unsigned STG_IFID = 0;
  localparam int unsigned STG_IDEX = 1;
  localparam int unsigned STG_EXWB = 2;
  localparam int unsigned NSTG     = 3;

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencing controller.
// Arbitrates jump, interrupt and stall requests, drives the PC update and
// per-stage keep/bubble controls, and flags a hung bus with a timeout pulse.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   jump_req_i/addr  : PC redirect request and target from EX
//   int_req_i/addr   : level interrupt request and vector from CLINT
//   hold_ex_req_i    : EX busy (multi-cycle op)
//   hold_bus_req_i   : fetch/LSU bus not ready
//   pc_hold_o        : PC keeps its value
//   pc_load_o        : PC loads pc_addr_o on the next edge
//   pc_addr_o        : new PC value (0 when not loading)
//   stall_o          : per-stage keep, bit order IF/ID, ID/EX, EX/WB
//   flush_o          : per-stage bubble (drives each stage's hold_en)
//   int_ack_o        : one-cycle interrupt acknowledge
//   bus_to_o         : one-cycle bus-timeout pulse
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned TO_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_req_i,
  input  logic [AW-1:0]   jump_addr_i,
  input  logic            int_req_i,
  input  logic [AW-1:0]   int_addr_i,
  input  logic            hold_ex_req_i,
  input  logic            hold_bus_req_i,
  output logic            pc_hold_o,
  output logic            pc_load_o,
  output logic [AW-1:0]   pc_addr_o,
  output logic [NSTG-1:0] stall_o,
  output logic [NSTG-1:0] flush_o,
  output logic            int_ack_o,
  output logic            bus_to_o
);

  localparam logic [3:0]      FC_INIT = 4'(FLUSH_CYC - 1);
  // 2**TO_W-2: last count value before the timeout fires
  localparam logic [TO_W-1:0] TO_MAX  = {{(TO_W-1){1'b1}}, 1'b0};

  pc_state_e       state_q, state_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            int_take;
  logic            redirect;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    tcnt_d    = '0;
    pc_hold_o = 1'b0;
    pc_load_o = 1'b0;
    pc_addr_o = '0;
    stall_o   = '0;
    flush_o   = '0;
    int_ack_o = 1'b0;
    bus_to_o  = 1'b0;

    int_take = int_req_i && (state_q == PC_RUN) && !jump_req_i &&
               !hold_ex_req_i && !hold_bus_req_i;
    redirect = jump_req_i || int_take;

    if (jump_req_i) begin
      pc_addr_o = jump_addr_i;
    end else if (int_take) begin
      pc_addr_o = int_addr_i;
      int_ack_o = 1'b1;
    end

    if (redirect) begin
      pc_load_o         = 1'b1;
      flush_o[STG_IFID] = 1'b1;
      flush_o[STG_IDEX] = 1'b1;
    end else if (hold_ex_req_i) begin
      // Bubble into EX/WB so writeback of the stalled op happens once.
      pc_hold_o         = 1'b1;
      stall_o[STG_IFID] = 1'b1;
      stall_o[STG_IDEX] = 1'b1;
      flush_o[STG_EXWB] = 1'b1;
    end else if (hold_bus_req_i) begin
      pc_hold_o         = 1'b1;
      stall_o[STG_IFID] = 1'b1;
      flush_o[STG_IDEX] = 1'b1;
    end

    if (state_q == PC_FLUSH) begin
      flush_o[STG_IFID] = 1'b1;
    end

    // A stage being bubbled cannot also keep its contents.
    stall_o = stall_o & ~flush_o;

    if (redirect) begin
      if (FLUSH_CYC > 1) begin
        state_d = PC_FLUSH;
        fcnt_d  = FC_INIT;
      end else begin
        state_d = PC_RUN;
        fcnt_d  = '0;
      end
    end else if ((state_q == PC_FLUSH) && !hold_bus_req_i) begin
      // Leaving when the count would hit zero keeps the bubble at exactly
      // FLUSH_CYC cycles including the redirect cycle.
      if (fcnt_q <= 4'd1) begin
        state_d = PC_RUN;
        fcnt_d  = '0;
      end else begin
        fcnt_d  = fcnt_q - 4'd1;
      end
    end

    if (hold_bus_req_i) begin
      if (tcnt_q == TO_MAX) begin
        bus_to_o = 1'b1;
        tcnt_d   = '0;
      end else begin
        tcnt_d   = tcnt_q + 1'b1;
      end
    end

    // Outputs must be quiet throughout reset, including its async assertion.
    if (!rst) begin
      pc_hold_o = 1'b0;
      pc_load_o = 1'b0;
      pc_addr_o = '0;
      stall_o   = '0;
      flush_o   = '0;
      int_ack_o = 1'b0;
      bus_to_o  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PC_RUN;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  typedef struct packed {
    logic        hold;
    logic        load;
    logic [31:0] addr;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic        ack;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_req_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        int_req_i = 1'b0;
  logic [31:0] int_addr_i = '0;
  logic        hold_ex_req_i = 1'b0;
  logic        hold_bus_req_i = 1'b0;
  logic        pc_hold_o;
  logic        pc_load_o;
  logic [31:0] pc_addr_o;
  logic [2:0]  stall_o;
  logic [2:0]  flush_o;
  logic        int_ack_o;
  logic        bus_to_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        sb[$];

  pipe_ctrl #(.AW(32), .FLUSH_CYC(2), .TO_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_req_i     (jump_req_i),
    .jump_addr_i    (jump_addr_i),
    .int_req_i      (int_req_i),
    .int_addr_i     (int_addr_i),
    .hold_ex_req_i  (hold_ex_req_i),
    .hold_bus_req_i (hold_bus_req_i),
    .pc_hold_o      (pc_hold_o),
    .pc_load_o      (pc_load_o),
    .pc_addr_o      (pc_addr_o),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .int_ack_o      (int_ack_o),
    .bus_to_o       (bus_to_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic hold, input logic load, input logic [31:0] addr,
                              input logic [2:0] stall, input logic [2:0] flush,
                              input logic ack, input logic to);
    exp_t e;
    e.hold = hold; e.load = load; e.addr = addr; e.stall = stall;
    e.flush = flush; e.ack = ack; e.to = to;
    return e;
  endfunction

  function automatic exp_t observed();
    return mk(pc_hold_o, pc_load_o, pc_addr_o, stall_o, flush_o, int_ack_o, bus_to_o);
  endfunction

  task automatic idle_inputs();
    jump_req_i = 1'b0; int_req_i = 1'b0; hold_ex_req_i = 1'b0; hold_bus_req_i = 1'b0;
    jump_addr_i = '0; int_addr_i = '0;
  endtask

  // Drive one cycle of inputs just after the rising edge, queue the expected
  // outputs, then compare against the DUT at the falling edge.
  task automatic step(input string tag, input logic j, input logic [31:0] ja,
                      input logic ir, input logic [31:0] ia,
                      input logic hex, input logic hbus, input exp_t e);
    exp_t want;
    @(posedge clk);
    #1;
    jump_req_i = j; jump_addr_i = ja; int_req_i = ir; int_addr_i = ia;
    hold_ex_req_i = hex; hold_bus_req_i = hbus;
    sb.push_back(e);
    @(negedge clk);
    want = sb.pop_front();
    check(tag, {22'b0, observed()}, {22'b0, want});
  endtask

  exp_t Z;

  initial begin
    Z = mk(0, 0, 32'h0, 3'b000, 3'b000, 0, 0);

    // Reset held with requests active
    step("rst_held0", 1, 32'h100, 1, 32'h200, 0, 0, Z);
    step("rst_held1", 1, 32'h100, 1, 32'h200, 1, 1, Z);
    idle_inputs();
    #1 rst = 1'b1;
    step("rst_jump",  1, 32'h100, 0, 0, 0, 0, mk(0, 1, 32'h100, 3'b000, 3'b011, 0, 0));
    step("rst_fl1",   0, 0, 0, 0, 0, 0, mk(0, 0, 0, 3'b000, 3'b001, 0, 0));
    step("rst_fl2",   0, 0, 0, 0, 0, 0, Z);

    // Jump bubble
    step("jb_jump", 1, 32'h80, 0, 0, 0, 0, mk(0, 1, 32'h80, 3'b000, 3'b011, 0, 0));
    step("jb_fl1",  0, 0, 0, 0, 0, 0, mk(0, 0, 0, 3'b000, 3'b001, 0, 0));
    step("jb_fl2",  0, 0, 0, 0, 0, 0, Z);

    // Bus hold inside FLUSH extends the bubble
    step("bh_jump", 1, 32'h80, 0, 0, 0, 0, mk(0, 1, 32'h80, 3'b000, 3'b011, 0, 0));
    step("bh_hold", 0, 0, 0, 0, 0, 1, mk(1, 0, 0, 3'b000, 3'b011, 0, 0));
    step("bh_fl",   0, 0, 0, 0, 0, 0, mk(0, 0, 0, 3'b000, 3'b001, 0, 0));
    step("bh_run",  0, 0, 0, 0, 0, 0, Z);

    // Interrupt pending behind hold_ex
    for (int i = 0; i < 3; i++)
      step("ie_hold", 0, 0, 1, 32'h200, 1, 0, mk(1, 0, 0, 3'b011, 3'b100, 0, 0));
    step("ie_ack",  0, 0, 1, 32'h200, 0, 0, mk(0, 1, 32'h200, 3'b000, 3'b011, 1, 0));
    step("ie_noack", 0, 0, 1, 32'h200, 0, 0, mk(0, 0, 0, 3'b000, 3'b001, 0, 0));
    step("ie_run",  0, 0, 0, 32'h200, 0, 0, Z);

    // Jump and interrupt together
    step("ji_jump", 1, 32'h300, 1, 32'h240, 0, 0, mk(0, 1, 32'h300, 3'b000, 3'b011, 0, 0));
    step("ji_fl",   0, 0, 1, 32'h240, 0, 0, mk(0, 0, 0, 3'b000, 3'b001, 0, 0));
    step("ji_ack",  0, 0, 1, 32'h240, 0, 0, mk(0, 1, 32'h240, 3'b000, 3'b011, 1, 0));
    step("ji_fl2",  0, 0, 0, 0, 0, 0, mk(0, 0, 0, 3'b000, 3'b001, 0, 0));
    step("ji_run",  0, 0, 0, 0, 0, 0, Z);

    // hold_ex during FLUSH: IF/ID bubble overrides its stall bit
    step("xf_jump", 1, 32'h400, 0, 0, 0, 0, mk(0, 1, 32'h400, 3'b000, 3'b011, 0, 0));
    step("xf_hex",  0, 0, 0, 0, 1, 0, mk(1, 0, 0, 3'b010, 3'b101, 0, 0));
    step("xf_run",  0, 0, 0, 0, 0, 0, Z);

    // hold_ex has priority over hold_bus
    step("xb_both", 0, 0, 0, 0, 1, 1, mk(1, 0, 0, 3'b011, 3'b100, 0, 0));
    step("xb_idle", 0, 0, 0, 0, 0, 0, Z);

    // Jump overrides bus hold; load wins over hold
    step("jh_jump", 1, 32'h500, 0, 0, 0, 1, mk(0, 1, 32'h500, 3'b000, 3'b011, 0, 0));
    step("jh_fl",   0, 0, 0, 0, 0, 0, mk(0, 0, 0, 3'b000, 3'b001, 0, 0));
    step("jh_run",  0, 0, 0, 0, 0, 0, Z);

    // Bus timeout with TO_W=4: pulses on hold cycles 15 and 30
    for (int i = 1; i <= 40; i++)
      step($sformatf("to_%0d", i), 0, 0, 0, 0, 0, 1,
           mk(1, 0, 0, 3'b001, 3'b010, 0, (i == 15) || (i == 30)));
    step("to_idle", 0, 0, 0, 0, 0, 0, Z);

    // Async reset in the middle of FLUSH
    step("ar_jump", 1, 32'h600, 0, 0, 0, 0, mk(0, 1, 32'h600, 3'b000, 3'b011, 0, 0));
    #2;
    jump_req_i = 1'b1; jump_addr_i = 32'h700; hold_bus_req_i = 1'b1;
    rst = 1'b0;
    #1;
    check("ar_async", {22'b0, observed()}, {22'b0, Z});
    @(posedge clk);
    #1;
    check("ar_held", {22'b0, observed()}, {22'b0, Z});
    idle_inputs();
    #1 rst = 1'b1;
    step("ar_run", 0, 0, 0, 0, 0, 0, Z);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
